// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, registered fetch output with a
// valid/ready handshake, redirects and a saturating accepted-instruction counter.
// Optional zero-word halt detection is enabled by defining FETCH_HALT_ON_ZERO_EN.
module imem_fetch_ctrl #(
    parameter logic [5:0] RESET_PC = 6'd0,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             redirect,
    input  logic [5:0]       redirect_addr,
    output logic [5:0]       imem_addr,
    input  logic [31:0]      imem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [5:0]       out_pc,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    logic [5:0]       r_pc;
    logic             r_valid;
    logic [31:0]      r_instr;
    logic [5:0]       r_out_pc;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_load;
    logic w_zero;
    logic w_cnt_max;

    assign w_accept  = r_valid && out_ready;
    assign w_load    = !r_valid || out_ready;
    assign w_cnt_max = &r_cnt;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign w_zero = (imem_data == 32'h0000_0000);
`else
    assign w_zero = 1'b0;
`endif

    assign imem_addr = r_pc;
    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_pc    = r_out_pc;
    assign fetch_cnt = r_cnt;
    assign halted    = (r_state == ST_HALTED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_instr  <= 32'h0000_0000;
            r_out_pc <= 6'd0;
            r_cnt    <= '0;
        end else begin
            // A handshake always counts, even when a redirect discards the pipeline.
            if (w_accept && !w_cnt_max)
                r_cnt <= r_cnt + CNT_W'(1);

            if (redirect) begin
                r_pc    <= redirect_addr;
                r_valid <= 1'b0;
                r_state <= ST_RUN;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept)
                            r_valid <= 1'b0;
                        if (start)
                            r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (w_load) begin
                            if (w_zero) begin
                                // Zero word is not presented and the PC stays on it.
                                r_valid <= 1'b0;
                                r_state <= ST_HALTED;
                            end else begin
                                r_instr  <= imem_data;
                                r_out_pc <= r_pc;
                                r_valid  <= 1'b1;
                                r_pc     <= r_pc + 6'd1;
                            end
                        end
                    end
                    ST_HALTED: begin
                        if (w_accept)
                            r_valid <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: sequencing, stall, redirect, wrap,
// zero-word behaviour (either build), counter saturation and async reset.
module tb_imem_fetch_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             redirect;
    logic [5:0]       redirect_addr;
    logic [5:0]       imem_addr;
    logic [31:0]      imem_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [5:0]       out_pc;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;

    logic [31:0] mem [64];
    int n_assert;
    int n_fail;
    int n_step;

    assign imem_data = mem[imem_addr];

    imem_fetch_ctrl #(
        .RESET_PC (6'd0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_step++;
        $display("step %0d: valid=%b pc=%0d instr=%h addr=%0d halted=%b cnt=%0d",
                 n_step, out_valid, out_pc, out_instr, imem_addr, halted, fetch_cnt);
    endtask

    task automatic chk_out(input string tag, input logic [5:0] pc, input logic [31:0] instr,
                           input logic [CNT_W-1:0] cnt);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, {26'd0, out_pc}, {26'd0, pc});
        chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_cnt"}, {28'd0, fetch_cnt}, {28'd0, cnt});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_instr"}, out_instr, 32'h0);
        chk({tag, "_pc"}, {26'd0, out_pc}, 32'd0);
        chk({tag, "_cnt"}, {28'd0, fetch_cnt}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_addr"}, {26'd0, imem_addr}, 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        n_step   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[0] = 32'h2002_0003;
        mem[1] = 32'h2007_0003;
        mem[7] = 32'h0000_0000;

        reset = 1'b1; start = 1'b0; redirect = 1'b0; redirect_addr = 6'd0; out_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        reset = 1'b0;

        // Start, then sequential fetch with consumer always ready
        start = 1'b1; out_ready = 1'b1;
        step();
        chk("start_valid", {31'd0, out_valid}, 32'd0);
        start = 1'b0;
        step(); chk_out("seq0", 6'd0, 32'h2002_0003, 4'd0);
        chk("seq0_addr", {26'd0, imem_addr}, 32'd1);
        step(); chk_out("seq1", 6'd1, 32'h2007_0003, 4'd1);
        step(); chk_out("seq2", 6'd2, 32'h1000_0002, 4'd2);

        // Stall for three cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out("stall", 6'd2, 32'h1000_0002, 4'd2);
            chk("stall_addr", {26'd0, imem_addr}, 32'd3);
        end
        out_ready = 1'b1;
        step(); chk_out("release", 6'd3, 32'h1000_0003, 4'd3);

        // Redirect with a handshake in the same cycle
        redirect = 1'b1; redirect_addr = 6'd5;
        step();
        chk("redir_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_cnt", {28'd0, fetch_cnt}, 32'd4);
        chk("redir_addr", {26'd0, imem_addr}, 32'd5);
        redirect = 1'b0;
        step(); chk_out("redir5", 6'd5, 32'h1000_0005, 4'd4);
        step(); chk_out("redir6", 6'd6, 32'h1000_0006, 4'd5);

        // PC wrap 63 -> 0
        redirect = 1'b1; redirect_addr = 6'd63;
        step(); chk("wrap_redir_valid", {31'd0, out_valid}, 32'd0);
        redirect = 1'b0;
        step(); chk_out("wrap63", 6'd63, 32'h1000_003F, 4'd6);
        step(); chk_out("wrap0", 6'd0, 32'h2002_0003, 4'd7);
        step(); chk_out("wrap1", 6'd1, 32'h2007_0003, 4'd8);

        // Zero word at address 7
        redirect = 1'b1; redirect_addr = 6'd6;
        step(); chk("z_redir_valid", {31'd0, out_valid}, 32'd0);
        redirect = 1'b0;
        step(); chk_out("z6", 6'd6, 32'h1000_0006, 4'd9);
        step();
`ifdef FETCH_HALT_ON_ZERO_EN
        chk("z_halted", {31'd0, halted}, 32'd1);
        chk("z_valid", {31'd0, out_valid}, 32'd0);
        chk("z_addr", {26'd0, imem_addr}, 32'd7);
        chk("z_cnt", {28'd0, fetch_cnt}, 32'd10);
        step();
        chk("z_hold_halted", {31'd0, halted}, 32'd1);
        chk("z_hold_addr", {26'd0, imem_addr}, 32'd7);
`else
        chk_out("z7", 6'd7, 32'h0000_0000, 4'd10);
        chk("z7_halted", {31'd0, halted}, 32'd0);
        step(); chk_out("z8", 6'd8, 32'h1000_0008, 4'd11);
`endif
        redirect = 1'b1; redirect_addr = 6'd0;
        step();
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_valid", {31'd0, out_valid}, 32'd0);
        redirect = 1'b0;
        step();
        chk("resume_instr", out_instr, 32'h2002_0003);
        chk("resume_pc", {26'd0, out_pc}, 32'd0);

        // Counter saturation
        for (int i = 0; i < 8; i++) step();
        chk("sat_cnt", {28'd0, fetch_cnt}, 32'd15);
        step();
        chk("sat_cnt_hold", {28'd0, fetch_cnt}, 32'd15);

        // Async reset mid-RUN with a valid output
        redirect = 1'b1; redirect_addr = 6'd2;
        step();
        redirect = 1'b0;
        step(); chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        #1 reset = 1'b0;
        step(); chk("idle_valid", {31'd0, out_valid}, 32'd0);
        step(); chk("idle_addr", {26'd0, imem_addr}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step(); chk_out("restart", 6'd0, 32'h2002_0003, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 6'd0, is the word address loaded into the PC at reset.
REQ-002 Parameter CNT_W, default 16, is the width of the accepted-instruction counter.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, is the reset, asynchronous and active-high.
REQ-005 Port start, input, 1, is a level from IDLE to RUN, ignored in other states.
REQ-006 Port redirect, input, 1, is a branch/jump request, sampled each cycle.
REQ-007 Port redirect_addr, input, 6, is the redirect target word address.
REQ-008 Port imem_addr, output, 6, is the instruction memory word address, combinationally equal to the PC.
REQ-009 Port imem_data, input, 32, is the instruction memory read data, combinational from imem_addr.
REQ-010 Port out_valid, output, 1, indicates out_instr/out_pc hold a fetched instruction.
REQ-011 Port out_ready, input, 1, indicates the consumer accepts this cycle.
REQ-012 Port out_instr, output, 32, is the registered fetched instruction.
REQ-013 Port out_pc, output, 6, is the word address out_instr was fetched from.
REQ-014 Port halted, output, 1, is high while in HALTED.
REQ-015 Port fetch_cnt, output, CNT_W, counts accepted instructions (out_valid && out_ready).

Function
REQ-016 The block SHALL implement states IDLE, RUN and HALTED.
REQ-017 IDLE -> RUN when start=1; RUN and HALTED ignore start.
REQ-018 In RUN, a load SHALL occur when out_valid=0 or out_ready=1: out_instr<=imem_data, out_pc<=PC, out_valid<=1, PC<=PC+1.
REQ-019 In RUN with out_valid=1 and out_ready=0, out_instr, out_pc, out_valid and PC SHALL hold (stall).
REQ-020 With no load in the same cycle, an accepted handshake SHALL clear out_valid.
REQ-021 Fetch latency SHALL be one cycle: word at PC appears on out_instr the cycle after the load edge.
REQ-022 PC SHALL wrap 63 -> 0 modulo 64 with no flag.
REQ-023 redirect=1 in any state SHALL take priority: PC<=redirect_addr, out_valid<=0, state<=RUN, no load that cycle.
REQ-024 The first fetch after redirect SHALL be from redirect_addr on the following cycle.
REQ-025 A handshake in a redirect cycle SHALL still increment fetch_cnt; the instruction is consumed, not squashed.
REQ-026 fetch_cnt SHALL saturate at 2^CNT_W-1.
REQ-027 In IDLE and HALTED, out_valid SHALL hold at 0 once any pending valid output is accepted; no loads occur.
REQ-028 halted SHALL be 1 exactly when state=HALTED.

Reset
REQ-029 On reset assertion the block SHALL asynchronously set: state=IDLE, PC=RESET_PC, out_valid=0, out_instr=32'h0, out_pc=6'd0, fetch_cnt=0, halted=0.
REQ-030 Reset asserted mid-RUN SHALL discard any held instruction; no handshake completes in that cycle.

Configuration
REQ-031 Macro FETCH_HALT_ON_ZERO_EN SHALL control zero-word halt detection.
REQ-032 With FETCH_HALT_ON_ZERO_EN defined, a RUN load seeing imem_data==32'h00000000 SHALL not present the word, leave out_valid as given by REQ-020, hold the PC, and enter HALTED.
REQ-033 Without FETCH_HALT_ON_ZERO_EN, 32'h00000000 SHALL be fetched as an ordinary instruction and HALTED is unreachable.
REQ-034 In both builds, redirect SHALL exit HALTED.

Verification
REQ-035 Reset, start=1, out_ready=1, image word0=32'h20020003, word1=32'h20070003 -> cycle1 out_instr=32'h20020003 out_pc=0; cycle2 32'h20070003 out_pc=1; fetch_cnt increments each cycle.
REQ-036 Valid at out_pc=2, out_ready=0 for 3 cycles -> out_instr/out_pc/imem_addr stable; release gives out_pc=3 next cycle with no skip or duplicate.
REQ-037 redirect=1, redirect_addr=5 while out_valid=1 at out_pc=3 -> next cycle out_valid=0; following cycle out_pc=5.
REQ-038 Redirect to 63, out_ready=1 (without macro) -> out_pc sequence 63, 0, 1.
REQ-039 Build with FETCH_HALT_ON_ZERO_EN, word7=0 -> after out_pc=6 accepted, halted=1, out_valid=0, imem_addr=7; redirect to 0 resumes with out_instr=32'h20020003.
REQ-040 Assert reset asynchronously mid-RUN with out_valid=1 -> outputs take REQ-029 values before the next clock edge; start required to resume from PC=0.
